// File: rtl/vmul_loader_if.sv
// Beat stream into the vector loader: one (a, x) element pair per accepted beat.
// Handshake: a beat transfers on a rising edge where in_valid && in_ready; in_ready never looks at in_valid.
interface vmul_loader_if #(
    parameter int INT_SIZE = 16
);
    logic                in_valid;
    logic                in_ready;
    logic [INT_SIZE-1:0] in_a;
    logic [INT_SIZE-1:0] in_x;
    logic                in_last;

    modport master (output in_valid, output in_a, output in_x, output in_last, input in_ready);
    modport slave  (input in_valid, input in_a, input in_x, input in_last, output in_ready);
endinterface

// File: rtl/vmul_loader.sv
// Assembles element beats into zero-padded vectors, issues them on stable a/x lanes
// and tags the downstream max result with y_valid/y_id PIPE_LATENCY cycles after issue.
module vmul_loader #(
    parameter int VECTOR_SIZE  = 16,
    parameter int INT_SIZE     = 16,
    parameter int PIPE_LATENCY = 5,
    parameter int ID_W         = 4
) (
    input  logic                            clock,
    input  logic                            resetn,
    vmul_loader_if.slave                    src,
    input  logic                            hold,
    output logic [VECTOR_SIZE*INT_SIZE-1:0] a,
    output logic [VECTOR_SIZE*INT_SIZE-1:0] x,
    output logic                            issue,
    output logic [ID_W-1:0]                 issue_id,
    output logic                            y_valid,
    output logic [ID_W-1:0]                 y_id,
    output logic                            dbg_state
);
    localparam int CW = $clog2(VECTOR_SIZE);
    localparam int VW = VECTOR_SIZE * INT_SIZE;

    typedef enum logic {FILL = 1'b0, FULL = 1'b1} state_t;

    state_t                 state, next_state;
    logic [CW-1:0]          cnt;
    logic [VW-1:0]          fill_a, fill_x;
    logic [VW-1:0]          merged_a, merged_x;
    logic [ID_W-1:0]        next_id;
    logic [PIPE_LATENCY-1:0] vld_sr;
    logic [ID_W-1:0]        id_sr [PIPE_LATENCY];
    logic                   accept, completing, load;

    assign src.in_ready = resetn && (state == FILL);
    assign accept       = src.in_valid && src.in_ready;
    assign completing   = accept && ((cnt == CW'(VECTOR_SIZE - 1)) || src.in_last);
    assign dbg_state    = (state == FULL);
    assign y_valid      = vld_sr[PIPE_LATENCY-1];
    assign y_id         = id_sr[PIPE_LATENCY-1];

    // Fill buffer with the current beat written into lane cnt and every higher lane forced to zero.
    always_comb begin
        merged_a = fill_a;
        merged_x = fill_x;
        for (int i = 0; i < VECTOR_SIZE; i++) begin
            if (i == int'(cnt)) begin
                merged_a[i*INT_SIZE +: INT_SIZE] = src.in_a;
                merged_x[i*INT_SIZE +: INT_SIZE] = src.in_x;
            end else if (i > int'(cnt)) begin
                merged_a[i*INT_SIZE +: INT_SIZE] = '0;
                merged_x[i*INT_SIZE +: INT_SIZE] = '0;
            end
        end
    end

    always_comb begin
        next_state = state;
        load       = 1'b0;
        case (state)
            FILL: begin
                if (completing) begin
                    if (hold) next_state = FULL;
                    else      load       = 1'b1;
                end
            end
            FULL: begin
                if (!hold) begin
                    load       = 1'b1;
                    next_state = FILL;
                end
            end
            default: next_state = FILL;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state    <= FILL;
            cnt      <= '0;
            fill_a   <= '0;
            fill_x   <= '0;
            a        <= '0;
            x        <= '0;
            issue    <= 1'b0;
            issue_id <= '0;
            next_id  <= '0;
            vld_sr   <= '0;
            for (int i = 0; i < PIPE_LATENCY; i++) id_sr[i] <= '0;
        end else begin
            state <= next_state;
            issue <= load;
            if (load) begin
                // In FILL the completing beat is still on the bus; in FULL it already sits in the buffer.
                a        <= (state == FILL) ? merged_a : fill_a;
                x        <= (state == FILL) ? merged_x : fill_x;
                issue_id <= next_id;
                next_id  <= next_id + 1'b1;
                fill_a   <= '0;
                fill_x   <= '0;
                cnt      <= '0;
            end else if (accept) begin
                fill_a <= merged_a;
                fill_x <= merged_x;
                cnt    <= completing ? '0 : cnt + 1'b1;
            end
            vld_sr   <= {vld_sr[PIPE_LATENCY-2:0], issue};
            id_sr[0] <= issue_id;
            for (int i = 1; i < PIPE_LATENCY; i++) id_sr[i] <= id_sr[i-1];
        end
    end
endmodule

// File: tb/tb_vmul_loader.sv
// Directed bench for vmul_loader: scoreboard queue of expected issues, monitors for issue and y_valid.
module tb_vmul_loader;
    localparam int VS  = 16;
    localparam int IS  = 16;
    localparam int PL  = 5;
    localparam int IDW = 4;
    localparam int VW  = VS * IS;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [VW-1:0]  a;
        logic [VW-1:0]  x;
        logic [31:0]    y;
        logic [31:0]    cyc;
    } exp_t;

    logic            clock = 1'b0;
    logic            resetn = 1'b0;
    logic            hold = 1'b0;
    logic [VW-1:0]   a, x;
    logic            issue, y_valid, dbg_state;
    logic [IDW-1:0]  issue_id, y_id;

    vmul_loader_if #(.INT_SIZE(IS)) bus ();

    vmul_loader #(.VECTOR_SIZE(VS), .INT_SIZE(IS), .PIPE_LATENCY(PL), .ID_W(IDW)) dut (
        .clock(clock), .resetn(resetn), .src(bus.slave), .hold(hold),
        .a(a), .x(x), .issue(issue), .issue_id(issue_id),
        .y_valid(y_valid), .y_id(y_id), .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clock = ~clock;
    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // scoreboard
    exp_t               exp_q[$];
    logic [IDW+31:0]    exp_y_q[$];
    int                 n_cmp = 0;
    int                 n_err = 0;

    logic [VW-1:0]  m_a, m_x;
    int             m_cnt;
    logic [IDW-1:0] m_id;
    exp_t           held_e;

    function automatic logic [31:0] max_prod(input logic [VW-1:0] av, input logic [VW-1:0] xv);
        logic [31:0] m, p;
        m = 0;
        for (int i = 0; i < VS; i++) begin
            p = 32'(av[i*IS +: IS]) * 32'(xv[i*IS +: IS]);
            if (p > m) m = p;
        end
        return m;
    endfunction

    task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    always @(negedge clock) begin
        exp_t e;
        logic [IDW+31:0] ey;
        if (issue === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL unexpected_issue: got issue_id %0d required none (cycle %0d)", issue_id, cyc);
            end else begin
                e = exp_q.pop_front();
                chk("issue_id", VW'(issue_id), VW'(e.id));
                chk("issue_cycle", VW'(cyc), VW'(e.cyc));
                chk("lanes_a", a, e.a);
                chk("lanes_x", x, e.x);
                chk("downstream_y", VW'(max_prod(a, x)), VW'(e.y));
                exp_y_q.push_back({e.id, e.cyc + 32'(PL)});
            end
        end
        if (y_valid === 1'b1) begin
            if (exp_y_q.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL unexpected_y_valid: got y_id %0d required none (cycle %0d)", y_id, cyc);
            end else begin
                ey = exp_y_q.pop_front();
                chk("y_id", VW'(y_id), VW'(ey[IDW+31:32]));
                chk("y_cycle", VW'(cyc), VW'(ey[31:0]));
            end
        end
    end

    // driver tasks
    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic send_beat(input logic [IS-1:0] av, input logic [IS-1:0] xv, input logic last);
        exp_t e;
        int   t;
        t = 0;
        bus.in_valid = 1'b1;
        bus.in_a     = av;
        bus.in_x     = xv;
        bus.in_last  = last;
        while (bus.in_ready !== 1'b1 && t < 50) begin
            @(posedge clock);
            #1;
            t++;
        end
        if (t >= 50) begin
            n_cmp++; n_err++;
            $display("FAIL beat_timeout: got in_ready %b required 1 (cycle %0d)", bus.in_ready, cyc);
            bus.in_valid = 1'b0;
            return;
        end
        @(posedge clock);
        #1;
        m_a[m_cnt*IS +: IS] = av;
        m_x[m_cnt*IS +: IS] = xv;
        if (last || m_cnt == VS - 1) begin
            e.id  = m_id;
            e.a   = m_a;
            e.x   = m_x;
            e.y   = max_prod(m_a, m_x);
            e.cyc = 32'(cyc);
            if (hold) held_e = e;
            else      exp_q.push_back(e);
            m_id  = m_id + 1'b1;
            m_a   = '0;
            m_x   = '0;
            m_cnt = 0;
        end else begin
            m_cnt++;
        end
    endtask

    task automatic do_reset();
        bus.in_valid = 1'b0;
        resetn = 1'b0;
        @(posedge clock);
        #1;
        chk("in_ready_in_reset", VW'(bus.in_ready), VW'(0));
        @(posedge clock);
        #1;
        chk("reset_a", a, '0);
        chk("reset_x", x, '0);
        chk("reset_issue", VW'(issue), VW'(0));
        chk("reset_issue_id", VW'(issue_id), VW'(0));
        chk("reset_y_valid", VW'(y_valid), VW'(0));
        chk("reset_y_id", VW'(y_id), VW'(0));
        resetn = 1'b1;
        #1;
        chk("in_ready_after_reset", VW'(bus.in_ready), VW'(1));
        m_a = '0; m_x = '0; m_cnt = 0; m_id = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test required finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [VW-1:0] a_prev;
        bus.in_valid = 1'b0;
        bus.in_a = '0;
        bus.in_x = '0;
        bus.in_last = 1'b0;
        m_a = '0; m_x = '0; m_cnt = 0; m_id = '0;
        @(posedge clock);
        #1;
        do_reset();

        // full vector: a = i+1, x = 2, y = 32
        for (int i = 0; i < VS; i++) send_beat(IS'(i + 1), 16'd2, 1'b0);
        idle(2);

        // short vector: (1,4), (4,2,last), y = 8
        send_beat(16'd1, 16'd4, 1'b0);
        send_beat(16'd4, 16'd2, 1'b1);
        idle(2);

        // hold across the completing beat, released after 3 cycles
        send_beat(16'd5, 16'd5, 1'b0);
        a_prev = a;
        hold = 1'b1;
        send_beat(16'd7, 16'd1, 1'b1);
        bus.in_valid = 1'b0;
        chk("in_ready_full", VW'(bus.in_ready), VW'(0));
        for (int k = 0; k < 3; k++) begin
            chk("issue_during_hold", VW'(issue), VW'(0));
            chk("a_stable_during_hold", a, a_prev);
            @(posedge clock);
            #1;
        end
        hold = 1'b0;
        @(posedge clock);
        #1;
        held_e.cyc = 32'(cyc);
        exp_q.push_back(held_e);
        chk("in_ready_after_release", VW'(bus.in_ready), VW'(1));
        idle(2);

        // in_valid toggling inside a vector
        for (int i = 0; i < VS; i++) begin
            send_beat(IS'(3 * i + 1), IS'(16 - i), 1'b0);
            idle(1);
        end
        idle(12);

        // reset mid-fill, then a full vector
        for (int i = 0; i < 7; i++) send_beat(16'hffff, 16'hffff, 1'b0);
        do_reset();
        for (int i = 0; i < VS; i++) send_beat(IS'(100 + i), 16'd3, 1'b0);
        idle(12);

        // reset mid-fill, then a short vector: lanes above 1 must read zero
        for (int i = 0; i < 5; i++) send_beat(16'h7777, 16'h8888, 1'b0);
        do_reset();
        send_beat(16'd9, 16'd9, 1'b0);
        send_beat(16'd2, 16'd2, 1'b1);
        idle(12);

        // 20 back-to-back single-beat vectors, ids wrap
        do_reset();
        for (int k = 0; k < 20; k++) send_beat(IS'(k + 1), IS'(k + 2), 1'b1);
        idle(15);

        chk("issue_queue_drained", VW'(exp_q.size()), VW'(0));
        chk("y_queue_drained", VW'(exp_y_q.size()), VW'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/vmul_loader.md
# vmul_loader

Upstream feeder for the pipelined vector multiply-and-max stage. It accepts (a, x) element pairs one per beat over a valid/ready stream and assembles them into full VECTOR_SIZE-lane vectors, zero-padding short vectors. It presents each completed vector on stable parallel `a`/`x` outputs and emits a `y_valid` tag aligned to when the downstream max result is valid.

## Interface
- VECTOR_SIZE, 16: lanes per vector; power of two, ≥2.
- INT_SIZE, 16: element width, unsigned.
- PIPE_LATENCY, 5: cycles from new `a`/`x` to valid `y` downstream; equals 1 + log2(VECTOR_SIZE).
- ID_W, 4: width of vector sequence id.

- clock  in  1  rising-edge clock.
- resetn  in  1  synchronous, active-low reset.
- in_valid  in  1  beat offered.
- in_ready  out  1  beat can be accepted.
- in_a  in  INT_SIZE  element of a.
- in_x  in  INT_SIZE  element of x.
- in_last  in  1  final beat of a short vector.
- hold  in  1  downstream asks that no new vector be issued.
- a  out  VECTOR_SIZE×INT_SIZE  packed lanes, lane 0 = first beat.
- x  out  VECTOR_SIZE×INT_SIZE  packed lanes.
- issue  out  1  one-cycle pulse: `a`/`x` changed this cycle.
- issue_id  out  ID_W  id of the vector currently on `a`/`x`.
- y_valid  out  1  downstream `y` corresponds to a newly issued vector this cycle.
- y_id  out  ID_W  id matching `y_valid`.

## Operation
- A beat is accepted on a rising edge with in_valid && in_ready. Lane index `cnt` (0..VECTOR_SIZE-1) selects the fill-buffer lane.
- Completing beat: cnt == VECTOR_SIZE-1, or in_last == 1. All lanes above cnt become 0. Zero products never win an unsigned max.
- in_last on the lane VECTOR_SIZE-1 beat has no extra effect.
- FSM states are FILL and FULL. Reset state is FILL.
- FILL:
  - in_ready = 1.
  - Completing beat with hold == 0 at the same edge: fill buffer (new beat merged, padded) loads `a`/`x`; `issue` goes high next cycle; cnt ← 0; fill buffer cleared; stay in FILL.
  - Completing beat with hold == 1: padded vector is kept in the fill buffer; go to FULL.
- FULL:
  - in_ready = 0.
  - On the first edge with hold == 0: load `a`/`x`, pulse `issue` next cycle, cnt ← 0, clear fill buffer, go to FILL.
- `a`/`x` are held stable between issues. Lanes never change outside a load.
- issue_id: increments by 1 at each load and wraps at 2^ID_W. The first issued vector has id 0.
- y_valid/y_id: `issue`/`issue_id` delayed exactly PIPE_LATENCY cycles through a shift register. Back-to-back issues produce back-to-back y_valid.
- `hold` does not affect the y_valid shift register. Vectors already issued always complete.

## Timing
- Reset (resetn low at an edge) sets: a = 0, x = 0, issue = 0, issue_id = 0, y_valid = 0, y_id = 0, all shift-register stages 0, cnt = 0, fill buffer = 0, state = FILL.
- While resetn is low, in_ready = 0 combinationally and no beat is accepted.
- Reset mid-fill or in FULL discards the partial or held vector. No issue occurs for it.
- Completing beat accepted at edge E: `a`/`x` are new from E; issue = 1 in the cycle after E; y_valid = 1 PIPE_LATENCY cycles after that.
- Throughput:
  - One beat per cycle while hold == 0.
  - A full vector every VECTOR_SIZE cycles.
  - Single-beat vectors (in_last on lane 0) can issue every cycle.
- in_ready depends only on state and resetn, never on in_valid.
- in_valid may drop mid-vector. cnt and the buffer are retained indefinitely.
- hold changing while in FILL with no completing beat has no effect.

## Test plan
- Full vector: lane i gets a = i+1, x = 2 for 16 consecutive beats, hold = 0 → issue pulses once the cycle after beat 15; a[15] = 16, x[15] = 2; y_valid 5 cycles later with y_id = 0; downstream y = 32.
- Short vector: beats (1,4) then (4,2, in_last) → a = {…0,4,1}, x = {…0,2,4}, lanes 2..15 = 0; downstream y = 8 on y_valid.
- Hold:
  - hold = 1 during the completing beat → in_ready = 0 next cycle, no issue, `a`/`x` unchanged.
  - Release hold after 3 cycles → issue the cycle after the release edge; in_ready = 1 again.
- Back-to-back single-beat vectors: in_last every beat for 20 beats → issue high 20 consecutive cycles; issue_id 0..15, 0..3 (wrap); y_valid high 20 consecutive cycles, ids matching, offset by 5.
- Reset mid-fill: 7 beats, resetn low one edge, then a full 16-beat vector → only one issue, id 0; no lane carries pre-reset data; y_valid never pulses for the aborted vector.
- Stall inside vector: in_valid toggles 1/0 across 16 beats → single issue after the 16th accepted beat; lane order preserved.
